arp_ctrl: RTL and testbench

Sequencer for the ARP transmit/receive engine. It resolves a target IP to a MAC by issuing ARP requests with timeout and retry. It answers incoming ARP requests with ARP replies, and it holds the one-entry peer cache (MAC/IP) that the UDP path uses for its Ethernet header. It sits between the user/top level and the ARP engine's user interface (`arp_tx_en`/`arp_tx_type`/`des_mac`/`des_ip`, `arp_rx_done`/`arp_rx_type`/`src_mac`/`src_ip`, `gmii_tx_done`).

---
 rtl/arp_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_arp_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_ctrl.sv
// ARP sequencer: resolves a target IP with timed retries, answers incoming
// ARP requests, and holds the single-entry peer cache used by the UDP path.
module arp_ctrl #(
    parameter int unsigned RETRY_CYCLES = 125_000_000,
    parameter int unsigned MAX_RETRY    = 4,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] target_ip,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        gmii_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic [47:0] peer_mac,
    output logic [31:0] peer_ip,
    output logic        peer_valid,
    output logic        resolve_fail,
    output logic        busy
);

    localparam int unsigned TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int unsigned AW = 4;
    localparam logic [TW-1:0] TMR_LAST  = TW'(RETRY_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX   = AW'(MAX_RETRY);
    localparam logic [47:0]   BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_REQ,
        S_WAIT_REQ_DONE,
        S_WAIT_REPLY,
        S_SEND_RSP,
        S_WAIT_RSP_DONE
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_req_pend,  w_req_pend_nxt;
    logic          r_rsp_pend,  w_rsp_pend_nxt;
    logic          r_got,       w_got_nxt;
    logic          r_auto_done;
    logic [31:0]   r_tgt_ip,    w_tgt_ip_nxt;
    logic [47:0]   r_rsp_mac,   w_rsp_mac_nxt;
    logic [31:0]   r_rsp_ip,    w_rsp_ip_nxt;
    logic [AW-1:0] r_attempt,   w_attempt_nxt;
    logic [TW-1:0] r_timer,     w_timer_nxt;
    logic          r_tx_en,     w_tx_en_nxt;
    logic          r_tx_type,   w_tx_type_nxt;
    logic [47:0]   r_des_mac,   w_des_mac_nxt;
    logic [31:0]   r_des_ip,    w_des_ip_nxt;
    logic [47:0]   r_peer_mac,  w_peer_mac_nxt;
    logic [31:0]   r_peer_ip,   w_peer_ip_nxt;
    logic          r_peer_valid, w_peer_valid_nxt;
    logic          r_fail,      w_fail_nxt;
    logic          r_busy,      w_busy_nxt;

    logic w_start, w_rx_req, w_match, w_rsp_any, w_in_prog;

    assign w_start   = start || ((AUTO_START != 0) && !r_auto_done);
    assign w_rx_req  = arp_rx_done && !arp_rx_type;
    assign w_match   = arp_rx_done && arp_rx_type && r_req_pend && (src_ip == r_tgt_ip);
    assign w_rsp_any = r_rsp_pend || w_rx_req;
    // A resolution is in progress once its first request has been launched
    assign w_in_prog = r_req_pend && (r_attempt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_pend   <= 1'b0;
            r_rsp_pend   <= 1'b0;
            r_got        <= 1'b0;
            r_auto_done  <= 1'b0;
            r_tgt_ip     <= '0;
            r_rsp_mac    <= '0;
            r_rsp_ip     <= '0;
            r_attempt    <= '0;
            r_timer      <= '0;
            r_tx_en      <= 1'b0;
            r_tx_type    <= 1'b0;
            r_des_mac    <= '0;
            r_des_ip     <= '0;
            r_peer_mac   <= '0;
            r_peer_ip    <= '0;
            r_peer_valid <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_pend   <= w_req_pend_nxt;
            r_rsp_pend   <= w_rsp_pend_nxt;
            r_got        <= w_got_nxt;
            r_auto_done  <= 1'b1;
            r_tgt_ip     <= w_tgt_ip_nxt;
            r_rsp_mac    <= w_rsp_mac_nxt;
            r_rsp_ip     <= w_rsp_ip_nxt;
            r_attempt    <= w_attempt_nxt;
            r_timer      <= w_timer_nxt;
            r_tx_en      <= w_tx_en_nxt;
            r_tx_type    <= w_tx_type_nxt;
            r_des_mac    <= w_des_mac_nxt;
            r_des_ip     <= w_des_ip_nxt;
            r_peer_mac   <= w_peer_mac_nxt;
            r_peer_ip    <= w_peer_ip_nxt;
            r_peer_valid <= w_peer_valid_nxt;
            r_fail       <= w_fail_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_req_pend_nxt   = r_req_pend;
        w_rsp_pend_nxt   = r_rsp_pend;
        w_got_nxt        = r_got;
        w_tgt_ip_nxt     = r_tgt_ip;
        w_rsp_mac_nxt    = r_rsp_mac;
        w_rsp_ip_nxt     = r_rsp_ip;
        w_attempt_nxt    = r_attempt;
        w_timer_nxt      = r_timer;
        w_tx_en_nxt      = 1'b0;
        w_tx_type_nxt    = r_tx_type;
        w_des_mac_nxt    = r_des_mac;
        w_des_ip_nxt     = r_des_ip;
        w_peer_mac_nxt   = r_peer_mac;
        w_peer_ip_nxt    = r_peer_ip;
        w_peer_valid_nxt = r_peer_valid;
        w_fail_nxt       = r_fail;

        // Event capture runs in every state; the state case may override it
        if (w_start && !r_req_pend) begin
            w_req_pend_nxt = 1'b1;
            w_tgt_ip_nxt   = target_ip;
        end
        if (w_rx_req) begin
            w_rsp_pend_nxt = 1'b1;
            w_rsp_mac_nxt  = src_mac;
            w_rsp_ip_nxt   = src_ip;
        end
        if (w_match) begin
            w_peer_mac_nxt   = src_mac;
            w_peer_ip_nxt    = src_ip;
            w_peer_valid_nxt = 1'b1;
            w_got_nxt        = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_rsp_any) begin
                    w_state_nxt = S_SEND_RSP;
                end else if (w_req_pend_nxt) begin
                    w_state_nxt   = S_SEND_REQ;
                    w_fail_nxt    = 1'b0;
                    w_attempt_nxt = AW'(1);
                end
            end
            S_SEND_REQ: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_type_nxt = 1'b0;
                w_des_mac_nxt = BCAST_MAC;
                w_des_ip_nxt  = r_tgt_ip;
                w_state_nxt   = S_WAIT_REQ_DONE;
            end
            S_WAIT_REQ_DONE: begin
                if (gmii_tx_done) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT_REPLY;
                end
            end
            S_WAIT_REPLY: begin
                // At the last timer value the timeout wins, so the reply
                // detour never stretches the window past RETRY_CYCLES
                if (w_match || r_got) begin
                    w_req_pend_nxt = 1'b0;
                    w_got_nxt      = 1'b0;
                    w_attempt_nxt  = '0;
                    w_state_nxt    = S_IDLE;
                end else if (r_timer == TMR_LAST) begin
                    if (r_attempt < ATT_MAX) begin
                        w_attempt_nxt = r_attempt + AW'(1);
                        w_state_nxt   = S_SEND_REQ;
                    end else begin
                        w_fail_nxt     = 1'b1;
                        w_req_pend_nxt = 1'b0;
                        w_attempt_nxt  = '0;
                        w_state_nxt    = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                    if (w_rsp_any) begin
                        w_state_nxt = S_SEND_RSP;
                    end
                end
            end
            S_SEND_RSP: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_type_nxt = 1'b1;
                w_des_mac_nxt = r_rsp_mac;
                w_des_ip_nxt  = r_rsp_ip;
                if (!w_rx_req) begin
                    w_rsp_pend_nxt = 1'b0;
                end
                w_state_nxt = S_WAIT_RSP_DONE;
            end
            S_WAIT_RSP_DONE: begin
                if (gmii_tx_done) begin
                    w_state_nxt = w_in_prog ? S_WAIT_REPLY : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign arp_tx_en    = r_tx_en;
    assign arp_tx_type  = r_tx_type;
    assign des_mac      = r_des_mac;
    assign des_ip       = r_des_ip;
    assign peer_mac     = r_peer_mac;
    assign peer_ip      = r_peer_ip;
    assign peer_valid   = r_peer_valid;
    assign resolve_fail = r_fail;
    assign busy         = r_busy;

endmodule

// File: tb/tb_arp_ctrl.sv
// Scoreboard bench for arp_ctrl: every launched frame is popped against the
// expected-frame queue; timing, cache and flag behaviour are checked inline.
module tb_arp_ctrl;

    localparam int unsigned RETRY = 100;
    localparam int unsigned MAXR  = 4;
    localparam int unsigned TXLAT = 4;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    typedef struct packed {
        logic        t;
        logic [47:0] mac;
        logic [31:0] ip;
    } frame_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] target_ip;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        gmii_tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [47:0] peer_mac;
    logic [31:0] peer_ip;
    logic        peer_valid;
    logic        resolve_fail;
    logic        busy;

    arp_ctrl #(
        .RETRY_CYCLES(RETRY),
        .MAX_RETRY   (MAXR),
        .AUTO_START  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .target_ip   (target_ip),
        .arp_rx_done (arp_rx_done),
        .arp_rx_type (arp_rx_type),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .gmii_tx_done(gmii_tx_done),
        .arp_tx_en   (arp_tx_en),
        .arp_tx_type (arp_tx_type),
        .des_mac     (des_mac),
        .des_ip      (des_ip),
        .peer_mac    (peer_mac),
        .peer_ip     (peer_ip),
        .peer_valid  (peer_valid),
        .resolve_fail(resolve_fail),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    frame_t q[$];
    frame_t mon_f;
    int n_tx = 0;
    int last_tx_cyc = 0;
    int n_done = 0;
    int last_done_cyc = 0;

    // Monitor: every launched frame must match the head of the queue
    always @(posedge clk) begin
        #1;
        if (arp_tx_en === 1'b1) begin
            n_tx++;
            last_tx_cyc = cyc;
            if (q.size() == 0) begin
                chk("sb_unexpected_tx", 64'(des_ip), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_f = q.pop_front();
                chk("tx_type", 64'(arp_tx_type), 64'(mon_f.t));
                chk("tx_des_mac", 64'(des_mac), 64'(mon_f.mac));
                chk("tx_des_ip", 64'(des_ip), 64'(mon_f.ip));
            end
        end
    end

    // Transmit-side model: completes each frame TXLAT cycles after launch
    initial begin
        gmii_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (arp_tx_en === 1'b1) begin
                repeat (TXLAT) @(negedge clk);
                gmii_tx_done  = 1'b1;
                last_done_cyc = cyc;
                n_done++;
                @(negedge clk);
                gmii_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic t, input logic [47:0] mac, input logic [31:0] ip);
        frame_t f;
        f.t = t;
        f.mac = mac;
        f.ip = ip;
        q.push_back(f);
    endtask

    task automatic drive_rx(input logic t, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1;
        arp_rx_type = t;
        src_mac     = mac;
        src_ip      = ip;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic wait_tx(input int prev, input int budget, input string tag);
        int k;
        k = 0;
        while (n_tx == prev && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(n_tx), 64'(prev + 1));
    endtask

    task automatic wait_done(input int prev, input int budget, input string tag);
        int k;
        k = 0;
        while (n_done == prev && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(n_done), 64'(prev + 1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_en"}, 64'(arp_tx_en), 64'(0));
        chk({tag, "_tx_type"}, 64'(arp_tx_type), 64'(0));
        chk({tag, "_des_mac"}, 64'(des_mac), 64'(0));
        chk({tag, "_des_ip"}, 64'(des_ip), 64'(0));
        chk({tag, "_peer_mac"}, 64'(peer_mac), 64'(0));
        chk({tag, "_peer_ip"}, 64'(peer_ip), 64'(0));
        chk({tag, "_peer_valid"}, 64'(peer_valid), 64'(0));
        chk({tag, "_fail"}, 64'(resolve_fail), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    int p;
    int s_cyc;
    int k_done;
    int rd;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        target_ip = '0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        src_mac = '0;
        src_ip = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Resolve C0A80003, answered after the request completes
        push(1'b0, BCAST, 32'hC0A8_0003);
        target_ip = 32'hC0A8_0003;
        start = 1'b1;
        s_cyc = cyc;
        p = n_tx;
        @(negedge clk);
        start = 1'b0;
        wait_tx(p, 20, "t1_req");
        chk("t1_latency", 64'(last_tx_cyc - s_cyc), 64'(2));
        chk("t1_busy", 64'(busy), 64'(1));
        p = n_done;
        wait_done(p, 20, "t1_done");
        @(negedge clk);
        drive_rx(1'b1, 48'hA82B_DD25_DA43, 32'hC0A8_0003);
        chk("t1_peer_mac", 64'(peer_mac), 64'hA82B_DD25_DA43);
        chk("t1_peer_ip", 64'(peer_ip), 64'hC0A8_0003);
        chk("t1_peer_valid", 64'(peer_valid), 64'(1));
        @(negedge clk);
        chk("t1_busy_idle", 64'(busy), 64'(0));

        // No answer: MAXR requests, each RETRY WAIT_REPLY cycles apart
        target_ip = 32'hC0A8_0007;
        for (int i = 0; i < int'(MAXR); i++) push(1'b0, BCAST, 32'hC0A8_0007);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(MAXR); i++) begin
            p = n_tx;
            wait_tx(p, 250, "t2_req");
            if (i > 0) chk("t2_gap", 64'(last_tx_cyc - last_done_cyc), 64'(RETRY + 2));
            p = n_done;
            wait_done(p, 20, "t2_done");
        end
        begin
            int k;
            k = 0;
            while (resolve_fail !== 1'b1 && k < 250) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t2_fail", 64'(resolve_fail), 64'(1));
        chk("t2_fail_time", 64'(cyc - last_done_cyc), 64'(RETRY + 1));
        chk("t2_peer_valid_kept", 64'(peer_valid), 64'(1));
        chk("t2_peer_mac_kept", 64'(peer_mac), 64'hA82B_DD25_DA43);
        chk("t2_busy", 64'(busy), 64'(0));
        p = n_tx;
        repeat (30) @(negedge clk);
        chk("t2_no_extra_req", 64'(n_tx), 64'(p));

        // Incoming request while idle is answered; cache untouched
        push(1'b1, 48'h1122_3344_5566, 32'hC0A8_0005);
        s_cyc = cyc;
        p = n_tx;
        drive_rx(1'b0, 48'h1122_3344_5566, 32'hC0A8_0005);
        wait_tx(p, 20, "t3_rsp");
        chk("t3_latency", 64'(last_tx_cyc - s_cyc), 64'(2));
        p = n_done;
        wait_done(p, 20, "t3_done");
        repeat (3) @(negedge clk);
        chk("t3_peer_mac", 64'(peer_mac), 64'hA82B_DD25_DA43);
        chk("t3_peer_ip", 64'(peer_ip), 64'hC0A8_0003);
        chk("t3_fail_held", 64'(resolve_fail), 64'(1));
        chk("t3_busy", 64'(busy), 64'(0));

        // Request arriving at timer=40 is answered; the timer then resumes
        push(1'b0, BCAST, 32'hC0A8_0008);
        target_ip = 32'hC0A8_0008;
        start = 1'b1;
        p = n_tx;
        @(negedge clk);
        start = 1'b0;
        wait_tx(p, 20, "t4_req");
        chk("t4_fail_cleared", 64'(resolve_fail), 64'(0));
        p = n_done;
        wait_done(p, 20, "t4_done");
        k_done = last_done_cyc;
        while (cyc < k_done + 41) @(negedge clk);
        push(1'b1, 48'h6655_4433_2211, 32'hC0A8_0006);
        push(1'b0, BCAST, 32'hC0A8_0008);
        p = n_tx;
        drive_rx(1'b0, 48'h6655_4433_2211, 32'hC0A8_0006);
        wait_tx(p, 20, "t4_rsp");
        p = n_done;
        wait_done(p, 20, "t4_rsp_done");
        rd = last_done_cyc;
        p = n_tx;
        wait_tx(p, 150, "t4_retry");
        chk("t4_resume", 64'(last_tx_cyc - rd), 64'((RETRY - 41) + 2));
        p = n_done;
        wait_done(p, 20, "t4_retry_done");
        @(negedge clk);
        drive_rx(1'b1, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0008);
        @(negedge clk);
        chk("t4_peer_mac", 64'(peer_mac), 64'h0A0B_0C0D_0E0F);
        chk("t4_peer_ip", 64'(peer_ip), 64'hC0A8_0008);
        chk("t4_busy", 64'(busy), 64'(0));

        // Simultaneous start and request: reply first, then the ARP request
        push(1'b1, 48'hC1C1_C1C1_C1C1, 32'hC0A8_000B);
        push(1'b0, BCAST, 32'hC0A8_000A);
        target_ip = 32'hC0A8_000A;
        start = 1'b1;
        drive_rx(1'b0, 48'hC1C1_C1C1_C1C1, 32'hC0A8_000B);
        start = 1'b0;
        p = n_tx;
        wait_tx(p, 20, "t5_rsp_first");
        p = n_tx;
        wait_tx(p, 40, "t5_req_second");
        // Two requests before service: only the newer one is answered
        push(1'b1, 48'hD2D2_D2D2_D2D2, 32'hC0A8_000D);
        drive_rx(1'b0, 48'hD1D1_D1D1_D1D1, 32'hC0A8_000C);
        drive_rx(1'b0, 48'hD2D2_D2D2_D2D2, 32'hC0A8_000D);
        p = n_tx;
        wait_tx(p, 30, "t5_rsp_newest");
        p = n_done;
        wait_done(p, 20, "t5_rsp_done");
        @(negedge clk);
        drive_rx(1'b1, 48'hDEAD_BEEF_0001, 32'hC0A8_0009);
        chk("t5_nomatch_mac", 64'(peer_mac), 64'h0A0B_0C0D_0E0F);
        chk("t5_nomatch_ip", 64'(peer_ip), 64'hC0A8_0008);
        chk("t5_nomatch_busy", 64'(busy), 64'(1));
        push(1'b0, BCAST, 32'hC0A8_000A);
        p = n_tx;
        wait_tx(p, 250, "t5_retry");

        // Reset while waiting for the frame to finish
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        p = n_tx;
        repeat (20) @(negedge clk);
        chk("midrst_no_relaunch", 64'(n_tx), 64'(p));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("sb_empty", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
